// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard and sequencing controller for the five-stage MIPS pipeline.
//   * Tuse/Tnew data-hazard detection against the E and M stage writers.
//   * Multiply/divide busy counter. Mult/div-family instructions wait in D
//     while the unit is busy or starting.
//   * Exception/interrupt request (req). It flushes every stage register and
//     overrides every stall.
//
// Ports
//   clk                      single clock, all state on posedge
//   reset                    asynchronous, active-low
//   D_rs, D_rt        [4:0]  source registers of the instruction in D
//   D_Tuse_rs/_rt     [1:0]  cycles until D needs the operand (3 = not read)
//   D_md                     D holds mult/multu/div/divu/mfhi/mflo/mthi/mtlo
//   E_A3, M_A3        [4:0]  destination register in E / M
//   E_T_new, M_T_new  [1:0]  cycles until the E / M result is available
//   E_RegWrite, M_RegWrite   E / M instruction writes the GRF
//   E_start                  mult/div unit starts in E this cycle
//   E_md_div                 with E_start: 1 = div/divu, 0 = mult/multu
//   int_req                  exception/interrupt taken at M this cycle
//   stall                    hold PC and regD, bubble regE (combinational)
//   req                      flush all stages, load handler PC (combinational)
//   md_busy                  mult/div unit busy (md_count != 0)
//   md_count          [3:0]  remaining busy cycles
//   stall_cycles     [31:0]  saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  D_rs,
   input  logic [4:0]  D_rt,
   input  logic [1:0]  D_Tuse_rs,
   input  logic [1:0]  D_Tuse_rt,
   input  logic        D_md,
   input  logic [4:0]  E_A3,
   input  logic [4:0]  M_A3,
   input  logic [1:0]  E_T_new,
   input  logic [1:0]  M_T_new,
   input  logic        E_RegWrite,
   input  logic        M_RegWrite,
   input  logic        E_start,
   input  logic        E_md_div,
   input  logic        int_req,
   output logic        stall,
   output logic        req,
   output logic        md_busy,
   output logic [3:0]  md_count,
   output logic [31:0] stall_cycles
);

   localparam logic [1:0] TUSE_NONE  = 2'd3;
   localparam logic [3:0] MULT_LOAD  = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD   = 4'(DIV_CYCLES);

   logic rs_stall;
   logic rt_stall;
   logic md_stall;

   // A source operand must wait when an older in-flight writer of the same
   // register produces its value later than D needs it. $0 is never a real
   // dependency, and an operand that is not read never waits. W has Tnew = 0
   // and is always covered by forwarding.
   function automatic logic src_stall(
      input logic [4:0] src,
      input logic [1:0] tuse,
      input logic       e_we,
      input logic [4:0] e_a3,
      input logic [1:0] e_tnew,
      input logic       m_we,
      input logic [4:0] m_a3,
      input logic [1:0] m_tnew
   );
      logic hit_e;
      logic hit_m;
      hit_e = e_we && (e_a3 == src) && (e_tnew > tuse);
      hit_m = m_we && (m_a3 == src) && (m_tnew > tuse);
      return (src != 5'd0) && (tuse != TUSE_NONE) && (hit_e || hit_m);
   endfunction

   // NOTE: combinational logic uses blocking '=' and gives every output a
   // default first, so no path through the block can infer a latch.
   always_comb begin
      rs_stall = 1'b0;
      rt_stall = 1'b0;
      md_stall = 1'b0;
      stall    = 1'b0;

      rs_stall = src_stall(D_rs, D_Tuse_rs, E_RegWrite, E_A3, E_T_new,
                           M_RegWrite, M_A3, M_T_new);
      rt_stall = src_stall(D_rt, D_Tuse_rt, E_RegWrite, E_A3, E_T_new,
                           M_RegWrite, M_A3, M_T_new);
      // A start in E this cycle occupies the unit just as a running count does.
      md_stall = D_md && (md_busy || E_start);
      // The flush request squashes the instruction in D anyway, so stalling
      // it would only hold a dead instruction.
      stall    = (rs_stall || rt_stall || md_stall) && !int_req;
   end

   assign req     = int_req;
   assign md_busy = (md_count != 4'd0);

   // NOTE: sequential state uses non-blocking '<=' so every flop samples the
   // pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         md_count <= 4'd0;
      end else if (E_start && !int_req) begin
         // The start in E is younger than a faulting M instruction, so a
         // concurrent int_req cancels it. A reload while busy is allowed;
         // the D stall normally keeps it from happening.
         md_count <= E_md_div ? DIV_LOAD : MULT_LOAD;
      end else if (md_count != 4'd0) begin
         // A running count is an older committed operation: int_req never
         // aborts it.
         md_count <= md_count - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cycles <= 32'd0;
      end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed testbench for hazard_ctrl. Each scenario task drives its stimulus
// on the falling edge and compares outputs inline. Combinational outputs are
// sampled 1 ns after the inputs change. Registered outputs are sampled on the
// falling edge that follows the rising edge that updated them.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   logic        clk;
   logic        reset;
   logic [4:0]  D_rs;
   logic [4:0]  D_rt;
   logic [1:0]  D_Tuse_rs;
   logic [1:0]  D_Tuse_rt;
   logic        D_md;
   logic [4:0]  E_A3;
   logic [4:0]  M_A3;
   logic [1:0]  E_T_new;
   logic [1:0]  M_T_new;
   logic        E_RegWrite;
   logic        M_RegWrite;
   logic        E_start;
   logic        E_md_div;
   logic        int_req;
   logic        stall;
   logic        req;
   logic        md_busy;
   logic [3:0]  md_count;
   logic [31:0] stall_cycles;

   int tests_run    = 0;
   int tests_failed = 0;

   hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk          (clk),
      .reset        (reset),
      .D_rs         (D_rs),
      .D_rt         (D_rt),
      .D_Tuse_rs    (D_Tuse_rs),
      .D_Tuse_rt    (D_Tuse_rt),
      .D_md         (D_md),
      .E_A3         (E_A3),
      .M_A3         (M_A3),
      .E_T_new      (E_T_new),
      .M_T_new      (M_T_new),
      .E_RegWrite   (E_RegWrite),
      .M_RegWrite   (M_RegWrite),
      .E_start      (E_start),
      .E_md_div     (E_md_div),
      .int_req      (int_req),
      .stall        (stall),
      .req          (req),
      .md_busy      (md_busy),
      .md_count     (md_count),
      .stall_cycles (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every wait below is a fixed number of clocks; this only guards against
   // a broken simulation.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic set_idle();
      D_rs       = 5'd0;
      D_rt       = 5'd0;
      D_Tuse_rs  = 2'd3;
      D_Tuse_rt  = 2'd3;
      D_md       = 1'b0;
      E_A3       = 5'd0;
      M_A3       = 5'd0;
      E_T_new    = 2'd0;
      M_T_new    = 2'd0;
      E_RegWrite = 1'b0;
      M_RegWrite = 1'b0;
      E_start    = 1'b0;
      E_md_div   = 1'b0;
      int_req    = 1'b0;
   endtask

   // Pulse reset on a falling edge and release it on the next falling edge.
   task automatic reset_dut();
      @(negedge clk);
      set_idle();
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      set_idle();
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if (md_count !== 4'd0) begin
         tests_failed++;
         $display("FAIL reset_md_count: got %0d, expected 0", md_count);
      end
      tests_run++;
      if (md_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_md_busy: got %b, expected 0", md_busy);
      end
      tests_run++;
      if (stall_cycles !== 32'd0) begin
         tests_failed++;
         $display("FAIL reset_stall_cycles: got %h, expected 0", stall_cycles);
      end
      tests_run++;
      if (stall !== 1'b0 || req !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_stall_req: got stall=%b req=%b, expected 0/0", stall, req);
      end
      reset = 1'b1;
   endtask

   task automatic test_load_use();
      reset_dut();
      // lw in E, consumer reads rs next cycle: Tnew 2 > Tuse 1.
      @(negedge clk);
      set_idle();
      E_RegWrite = 1'b1; E_A3 = 5'd8; E_T_new = 2'd2;
      D_rs = 5'd8; D_Tuse_rs = 2'd1;
      #1;
      tests_run++;
      if (stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL load_use_E: got stall=%b, expected 1", stall);
      end
      // Same lw now in M with Tnew 1: forwarding covers Tuse 1.
      @(negedge clk);
      E_RegWrite = 1'b0; E_A3 = 5'd0; E_T_new = 2'd0;
      M_RegWrite = 1'b1; M_A3 = 5'd8; M_T_new = 2'd1;
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL load_use_M_resolved: got stall=%b, expected 0", stall);
      end
      // rt consumer needs it immediately (Tuse 0) against M Tnew 1.
      @(negedge clk);
      D_rs = 5'd0; D_Tuse_rs = 2'd3;
      D_rt = 5'd8; D_Tuse_rt = 2'd0;
      #1;
      tests_run++;
      if (stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL rt_M_hazard: got stall=%b, expected 1", stall);
      end
      // Boundary: E Tnew equal to Tuse is forwardable.
      @(negedge clk);
      set_idle();
      E_RegWrite = 1'b1; E_A3 = 5'd9; E_T_new = 2'd1;
      D_rt = 5'd9; D_Tuse_rt = 2'd1;
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL tnew_eq_tuse: got stall=%b, expected 0", stall);
      end
      // Register mismatch: no dependency.
      @(negedge clk);
      E_T_new = 2'd2; D_rt = 5'd10; D_Tuse_rt = 2'd0;
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL reg_mismatch: got stall=%b, expected 0", stall);
      end
      // Two stall cycles were seen (first and third steps).
      @(negedge clk);
      set_idle();
      tests_run++;
      if (stall_cycles !== 32'd2) begin
         tests_failed++;
         $display("FAIL load_use_count: got %0d, expected 2", stall_cycles);
      end
   endtask

   task automatic test_zero_unused();
      @(negedge clk);
      set_idle();
      E_RegWrite = 1'b1; E_A3 = 5'd0; E_T_new = 2'd2;
      D_rs = 5'd0; D_Tuse_rs = 2'd0;
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL zero_reg: got stall=%b, expected 0", stall);
      end
      E_A3 = 5'd8; D_rt = 5'd8; D_Tuse_rt = 2'd3;
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL unused_operand: got stall=%b, expected 0", stall);
      end
      E_RegWrite = 1'b0; D_Tuse_rt = 2'd0;
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL no_regwrite: got stall=%b, expected 0", stall);
      end
   endtask

   // Start a mult/div with a dependent md instruction held in D and follow
   // the countdown from n to 0.
   task automatic run_md(input logic is_div, input int n, input string tag);
      reset_dut();
      @(negedge clk);
      set_idle();
      E_start = 1'b1; E_md_div = is_div; D_md = 1'b1;
      #1;
      tests_run++;
      if (stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s_start_stall: got stall=%b, expected 1", tag, stall);
      end
      for (int k = n; k >= 1; k--) begin
         @(negedge clk);
         E_start = 1'b0;
         #1;
         tests_run++;
         if (md_count !== 4'(k) || md_busy !== 1'b1 || stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_count_%0d: got count=%0d busy=%b stall=%b, expected %0d/1/1",
                     tag, k, md_count, md_busy, stall, k);
         end
      end
      @(negedge clk);
      #1;
      tests_run++;
      if (md_count !== 4'd0 || md_busy !== 1'b0 || stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s_done: got count=%0d busy=%b stall=%b, expected 0/0/0",
                  tag, md_count, md_busy, stall);
      end
      tests_run++;
      if (stall_cycles !== 32'(n + 1)) begin
         tests_failed++;
         $display("FAIL %s_stall_cycles: got %0d, expected %0d", tag, stall_cycles, n + 1);
      end
      set_idle();
   endtask

   task automatic test_mult_busy();
      run_md(1'b0, 5, "mult");
   endtask

   task automatic test_div_busy();
      run_md(1'b1, 10, "div");
   endtask

   task automatic test_interrupt();
      reset_dut();
      // int_req together with a load-use hazard, a D md instruction and a start.
      @(negedge clk);
      set_idle();
      E_RegWrite = 1'b1; E_A3 = 5'd8; E_T_new = 2'd2;
      D_rs = 5'd8; D_Tuse_rs = 2'd1; D_md = 1'b1;
      E_start = 1'b1; int_req = 1'b1;
      #1;
      tests_run++;
      if (stall !== 1'b0 || req !== 1'b1) begin
         tests_failed++;
         $display("FAIL int_priority: got stall=%b req=%b, expected 0/1", stall, req);
      end
      @(negedge clk);
      set_idle();
      tests_run++;
      if (md_count !== 4'd0 || stall_cycles !== 32'd0) begin
         tests_failed++;
         $display("FAIL int_blocks_start: got count=%0d stall_cycles=%0d, expected 0/0",
                  md_count, stall_cycles);
      end
      // Start a div and let it run down to 3 (loaded 10, then 7 decrements).
      E_start = 1'b1; E_md_div = 1'b1;
      @(negedge clk);
      set_idle();
      repeat (7) @(negedge clk);
      tests_run++;
      if (md_count !== 4'd3) begin
         tests_failed++;
         $display("FAIL int_setup: got count=%0d, expected 3", md_count);
      end
      // int_req with a simultaneous start: no reload, running count continues.
      int_req = 1'b1; E_start = 1'b1; E_md_div = 1'b0;
      @(negedge clk);
      set_idle();
      tests_run++;
      if (md_count !== 4'd2) begin
         tests_failed++;
         $display("FAIL int_keeps_count: got count=%0d, expected 2", md_count);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_async_reset();
      reset_dut();
      // Twelve load-use stall cycles.
      @(negedge clk);
      set_idle();
      E_RegWrite = 1'b1; E_A3 = 5'd4; E_T_new = 2'd2;
      D_rs = 5'd4; D_Tuse_rs = 2'd0;
      repeat (12) @(negedge clk);
      set_idle();
      // Div start, then three more edges: 10 -> 7.
      E_start = 1'b1; E_md_div = 1'b1;
      @(negedge clk);
      set_idle();
      repeat (3) @(negedge clk);
      tests_run++;
      if (md_count !== 4'd7 || stall_cycles !== 32'd12) begin
         tests_failed++;
         $display("FAIL async_setup: got count=%0d stall_cycles=%0d, expected 7/12",
                  md_count, stall_cycles);
      end
      // Reset between edges, with a hazard present and int_req asserted later.
      #2;
      reset = 1'b0;
      E_RegWrite = 1'b1; E_A3 = 5'd4; E_T_new = 2'd2;
      D_rs = 5'd4; D_Tuse_rs = 2'd0;
      #1;
      tests_run++;
      if (md_count !== 4'd0 || md_busy !== 1'b0 || stall_cycles !== 32'd0) begin
         tests_failed++;
         $display("FAIL async_clear: got count=%0d busy=%b stall_cycles=%0d, expected 0/0/0",
                  md_count, md_busy, stall_cycles);
      end
      tests_run++;
      if (stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL stall_in_reset: got stall=%b, expected 1", stall);
      end
      int_req = 1'b1;
      #1;
      tests_run++;
      if (stall !== 1'b0 || req !== 1'b1) begin
         tests_failed++;
         $display("FAIL req_in_reset: got stall=%b req=%b, expected 0/1", stall, req);
      end
      // Held in reset across an edge, nothing counts.
      @(negedge clk);
      int_req = 1'b0;
      E_start = 1'b1;
      @(negedge clk);
      tests_run++;
      if (md_count !== 4'd0 || stall_cycles !== 32'd0) begin
         tests_failed++;
         $display("FAIL held_in_reset: got count=%0d stall_cycles=%0d, expected 0/0",
                  md_count, stall_cycles);
      end
      // Release: the next edge counts one stall and loads a mult.
      reset = 1'b1;
      E_md_div = 1'b0;
      @(negedge clk);
      set_idle();
      tests_run++;
      if (md_count !== 4'd5 || stall_cycles !== 32'd1) begin
         tests_failed++;
         $display("FAIL after_release: got count=%0d stall_cycles=%0d, expected 5/1",
                  md_count, stall_cycles);
      end
   endtask

   task automatic test_saturation();
      reset_dut();
      @(negedge clk);
      set_idle();
      force dut.stall_cycles = 32'hFFFF_FFFE;
      E_RegWrite = 1'b1; E_A3 = 5'd3; E_T_new = 2'd2;
      D_rt = 5'd3; D_Tuse_rt = 2'd1;
      #1;
      release dut.stall_cycles;
      @(negedge clk);
      tests_run++;
      if (stall_cycles !== 32'hFFFF_FFFF) begin
         tests_failed++;
         $display("FAIL sat_reach: got %h, expected ffffffff", stall_cycles);
      end
      repeat (2) @(negedge clk);
      set_idle();
      tests_run++;
      if (stall_cycles !== 32'hFFFF_FFFF) begin
         tests_failed++;
         $display("FAIL sat_hold: got %h, expected ffffffff", stall_cycles);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_zero_unused();
      test_mult_busy();
      test_div_busy();
      test_interrupt();
      test_async_reset();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage MIPS core. It computes the stall that freezes PC and regD and bubbles regE, using the Tuse/Tnew scheme carried through the stage registers. It owns the multiply/divide busy counter, so mult/div-family instructions wait in D while the unit is busy. It also gives the exception/interrupt request (`req`, which flushes every stage register) priority over every stall.

## Interface
- MULT_CYCLES, 5, busy cycles after a mult/multu start (1..15)
- DIV_CYCLES, 10, busy cycles after a div/divu start (1..15)

- clk  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-low; clears all state immediately when 0
- D_rs, D_rt  in  5  source register numbers of the instruction in D
- D_Tuse_rs, D_Tuse_rt  in  2  cycles until D needs the operand; 3 = operand not read
- D_md  in  1  D holds mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- E_A3, M_A3  in  5  destination register in E / M
- E_T_new, M_T_new  in  2  cycles until the E / M result is available
- E_RegWrite, M_RegWrite  in  1  E / M instruction writes the GRF
- E_start  in  1  mult/div unit starts in E this cycle
- E_md_div  in  1  with E_start: 1 = div/divu, 0 = mult/multu
- int_req  in  1  exception/interrupt taken at M this cycle
- stall  out  1  hold PC and regD, clear regE (combinational)
- req  out  1  flush all stage registers, load handler PC (combinational, = int_req)
- md_busy  out  1  mult/div unit busy (registered: md_count != 0)
- md_count  out  4  remaining busy cycles
- stall_cycles  out  32  saturating count of cycles in which stall = 1

## Operation
- Data stall for rs: D_rs != 0, D_Tuse_rs != 3, and either of:
  - E_RegWrite && E_A3 == D_rs && E_T_new > D_Tuse_rs
  - M_RegWrite && M_A3 == D_rs && M_T_new > D_Tuse_rs
- Data stall for rt: same rule with D_rt and D_Tuse_rt.
- Forwarding covers every other case. The W stage never stalls, since W's Tnew is always 0.
- md stall = D_md && (md_busy || E_start).
- stall = (rs stall || rt stall || md stall) && !int_req. req overrides all stalls.
- md counter, updated on each posedge:
  - if E_start && !int_req: load DIV_CYCLES when E_md_div = 1, otherwise MULT_CYCLES.
  - else if md_count != 0: decrement by 1.
  - else: hold at 0.
- Blocking rules for the counter:
  - int_req blocks a start: the E instruction is younger than the faulting one and gets flushed.
  - int_req does not abort a count already running: the older mult/div is architecturally committed.
- E_start while md_busy: counter reloads. The D stall normally prevents this case.
- stall_cycles increments on each posedge where stall = 1, and saturates at 32'hFFFF_FFFF.
- Reset (reset = 0, asynchronous, also mid-count) gives: md_count = 0, md_busy = 0, stall_cycles = 0.
- stall and req follow their inputs combinationally during reset.

## Timing
- stall and req: zero latency, same cycle as their inputs; no internal state.
- Counter run: E_start sampled at edge t → md_count = N after edge t, decreasing by 1 per cycle, 0 after edge t+N.
- md_busy is high for exactly N cycles after the start edge.
- A D mult/div-family instruction therefore stalls during the E_start cycle plus N busy cycles, and issues on the first cycle where md_busy = 0 and E_start = 0.
- stall_cycles reflects a stall cycle one edge later.
- Simultaneous E_start and int_req: no load. An already-running count continues to decrement.
- Reset release: first counting edge is the first posedge with reset = 1.

## Test plan
- Load-use stall:
  - Stimulus: lw in E (E_A3 = 8, E_T_new = 2, E_RegWrite = 1); D_rs = 8, D_Tuse_rs = 1.
  - Required: stall = 1.
  - Next cycle, same lw in M with M_T_new = 1: stall = 0.
- $0 and unused operand:
  - Stimulus: E_A3 = 0, D_rs = 0 with E_T_new = 2.
  - Required: stall = 0.
  - Also D_rt = 8 with D_Tuse_rt = 3 against an E write to 8: stall = 0.
- Mult/div busy:
  - Stimulus: E_start, E_md_div = 0, then D_md = 1 held.
  - Required: md_count goes 5,4,3,2,1,0; stall = 1 for the start cycle plus 5 cycles, then 0.
  - With E_md_div = 1: md_count runs 10 down to 0.
- Interrupt priority:
  - Stimulus: int_req = 1 together with a load-use hazard and E_start.
  - Required: stall = 0, req = 1, md_count stays 0.
  - Stimulus: int_req = 1 with md_count = 3.
  - Required: next md_count = 2.
- Asynchronous reset mid-operation:
  - Stimulus: reset = 0 between edges with md_count = 7 and stall_cycles = 12.
  - Required: both outputs read 0 immediately, before the next edge; counting resumes after release.
- Saturation:
  - Stimulus: force stall_cycles to 32'hFFFF_FFFE with stall held high for 3 cycles.
  - Required: stall_cycles ends at 32'hFFFF_FFFF.
